// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered, flow-controlled immediate decode stage between fetch and
//   register-read. Each accepted instruction is classified by format and its
//   immediate is sign- or zero-extended to XLEN. Results wait in a DEPTH-entry
//   FIFO with valid/ready on both sides.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           empties the buffer next cycle; a same-cycle push is dropped
//   in_valid/ready  upstream handshake (in_ready = !full && !reset)
//   instruction, pc instruction word and its PC
//   out_valid/ready downstream handshake for the head entry
//   imm_value       extended immediate of the head (0 when !out_valid)
//   imm_type        0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 illegal
//   illegal         head entry is an unsupported encoding
//   pc_out          PC of the head entry
//   illegal_count   accepted illegal instructions, saturating at 0xFFFF
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_value,
  output logic [2:0]      imm_type,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out,
  output logic [15:0]     illegal_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = XLEN + 3 + 1 + XLEN;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_Z   = 3'd6;
  localparam logic [2:0] T_ILL = 3'd7;

  localparam bit IS_RV64 = (XLEN == 64);

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic        is_shift;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh32, imm_zimm, imm_csr;
  logic [63:0] dec_imm64;
  logic [2:0]  dec_type;
  logic        dec_ill;

  assign opcode   = instruction[6:0];
  // funct3 001 (SLLI) and 101 (SRLI/SRAI) share funct3[1:0] = 01
  assign is_shift = (instruction[13:12] == 2'b01);

  // All formats are built at 64 bits and truncated to XLEN afterwards.
  assign imm_i    = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s    = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b    = {{51{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u    = {{32{instruction[31]}}, instruction[31:12], 12'b0};
  assign imm_j    = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
  // RV64 shift amounts are 6 bits wide; the *W shifts stay at 5 bits.
  assign imm_sh   = IS_RV64 ? {58'b0, instruction[25:20]} : {59'b0, instruction[24:20]};
  assign imm_sh32 = {59'b0, instruction[24:20]};
  assign imm_zimm = {59'b0, instruction[19:15]};
  assign imm_csr  = {52'b0, instruction[31:20]};

  always_comb begin
    dec_imm64 = '0;
    dec_type  = T_ILL;
    dec_ill   = 1'b1;
    if (instruction[1:0] == 2'b11) begin
      case (opcode)
        7'b0110011: begin dec_type = T_R; dec_ill = 1'b0; end
        7'b0111011: if (IS_RV64) begin dec_type = T_R; dec_ill = 1'b0; end
        7'b0000011,
        7'b1100111: begin dec_type = T_I; dec_ill = 1'b0; dec_imm64 = imm_i; end
        7'b0010011: begin
          dec_ill   = 1'b0;
          dec_type  = is_shift ? T_Z : T_I;
          dec_imm64 = is_shift ? imm_sh : imm_i;
        end
        7'b0011011: if (IS_RV64) begin
          dec_ill   = 1'b0;
          dec_type  = is_shift ? T_Z : T_I;
          dec_imm64 = is_shift ? imm_sh32 : imm_i;
        end
        7'b0100011: begin dec_type = T_S; dec_ill = 1'b0; dec_imm64 = imm_s; end
        7'b1100011: begin dec_type = T_B; dec_ill = 1'b0; dec_imm64 = imm_b; end
        7'b0110111,
        7'b0010111: begin dec_type = T_U; dec_ill = 1'b0; dec_imm64 = imm_u; end
        7'b1101111: begin dec_type = T_J; dec_ill = 1'b0; dec_imm64 = imm_j; end
        7'b1110011: begin
          dec_ill   = 1'b0;
          // funct3[2] selects the CSR*I forms carrying a 5-bit zimm in rs1
          dec_type  = instruction[14] ? T_Z : T_I;
          dec_imm64 = instruction[14] ? imm_zimm : imm_csr;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- buffer
  logic [ENT_W-1:0] entry_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [15:0]      illegal_count_reg;
  logic [ENT_W-1:0] wr_entry, head_entry;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_reg != FULL_CNT) && !reset;
  assign out_valid = (count_reg != '0);
  // A push coinciding with flush is discarded entirely.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign wr_entry   = {dec_imm64[XLEN-1:0], dec_type, dec_ill, pc};
  assign head_entry = entry_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      entry_mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_count_reg <= '0;
    end else if (push && dec_ill && (illegal_count_reg != 16'hFFFF)) begin
      illegal_count_reg <= illegal_count_reg + 16'd1;
    end
  end

  // Head fields are zeroed whenever the buffer is empty.
  assign imm_value     = out_valid ? head_entry[ENT_W-1 -: XLEN] : '0;
  assign imm_type      = out_valid ? head_entry[XLEN+3 -: 3]     : '0;
  assign illegal       = out_valid ? head_entry[XLEN]            : 1'b0;
  assign pc_out        = out_valid ? head_entry[XLEN-1:0]        : '0;
  assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage. Three instances (RV32 depth 2, RV64 depth 3,
// RV32 depth 1) share one stimulus stream. A driver-side process pushes the
// reference-model result into a per-instance scoreboard queue at each accepted
// handshake; a monitor process compares DUT outputs against the queue head.
module tb_imm_decode_stage;

  localparam int N = 3;
  localparam int XL [N] = '{32, 64, 32};
  localparam int DP [N] = '{2, 3, 1};

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic [63:0] pc;

  logic        in_ready  [N];
  logic        out_valid [N];
  logic        illegal_o [N];
  logic [2:0]  type_o    [N];
  logic [15:0] cnt_o     [N];
  logic [63:0] imm_o     [N];
  logic [63:0] pc_o      [N];

  exp_t        sb [N][$];
  logic [15:0] exp_cnt [N];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int W = XL[gi];
    logic [W-1:0] imm_w, pco_w;
    imm_decode_stage #(.XLEN(W), .DEPTH(DP[gi])) u_dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready[gi]),
      .instruction  (instruction),
      .pc           (pc[W-1:0]),
      .out_valid    (out_valid[gi]),
      .out_ready    (out_ready),
      .imm_value    (imm_w),
      .imm_type     (type_o[gi]),
      .illegal      (illegal_o[gi]),
      .pc_out       (pco_w),
      .illegal_count(cnt_o[gi])
    );
    assign imm_o[gi] = 64'(imm_w);
    assign pc_o[gi]  = 64'(pco_w);
  end

  // Reference decode written from the format rules with integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] i, input int xlen,
                                      input logic [63:0] pcv);
    exp_t        e;
    longint      s, hi, v;
    logic [63:0] u, shmask;
    s = longint'($signed(i));
    u = 64'(i);
    v = 0;
    e.typ = 3'd7;
    e.ill = 1'b1;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h33: begin e.typ = 3'd0; e.ill = 1'b0; end
        7'h3B: if (xlen == 64) begin e.typ = 3'd0; e.ill = 1'b0; end
        7'h03, 7'h67: begin e.typ = 3'd1; e.ill = 1'b0; v = s >>> 20; end
        7'h13, 7'h1B: if (i[6:0] == 7'h13 || xlen == 64) begin
          e.ill = 1'b0;
          if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
            shmask = (i[6:0] == 7'h13 && xlen == 64) ? 64'd63 : 64'd31;
            e.typ = 3'd6;
            v = longint'((u >> 20) & shmask);
          end else begin
            e.typ = 3'd1;
            v = s >>> 20;
          end
        end
        7'h23: begin
          e.typ = 3'd2; e.ill = 1'b0;
          hi = s >>> 25;
          v = hi <<< 5;
          v = v | longint'((u >> 7) & 64'd31);
        end
        7'h63: begin
          e.typ = 3'd3; e.ill = 1'b0;
          hi = s >>> 31;
          v = hi <<< 12;
          v = v | longint'((((u >> 7) & 64'd1) << 11) | (((u >> 25) & 64'd63) << 5)
                           | (((u >> 8) & 64'd15) << 1));
        end
        7'h37, 7'h17: begin
          e.typ = 3'd4; e.ill = 1'b0;
          v = s & longint'(64'hFFFF_FFFF_FFFF_F000);
        end
        7'h6F: begin
          e.typ = 3'd5; e.ill = 1'b0;
          hi = s >>> 31;
          v = hi <<< 20;
          v = v | longint'((((u >> 12) & 64'd255) << 12) | (((u >> 20) & 64'd1) << 11)
                           | (((u >> 21) & 64'd1023) << 1));
        end
        7'h73: begin
          e.ill = 1'b0;
          if (i[14]) begin e.typ = 3'd6; v = longint'((u >> 15) & 64'd31); end
          else       begin e.typ = 3'd1; v = longint'((u >> 20) & 64'd4095); end
        end
        default: ;
      endcase
    end
    e.imm = 64'(v);
    e.pc  = pcv;
    if (xlen == 32) begin
      e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
      e.pc  = e.pc  & 64'h0000_0000_FFFF_FFFF;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  // Monitor: compares every cycle, then retires/clears scoreboard entries
  // according to this cycle's handshake, flush and reset.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk("in_ready", k, 64'(in_ready[k]), 64'(!reset && (sb[k].size() < DP[k])));
      chk("out_valid", k, 64'(out_valid[k]), 64'(sb[k].size() != 0));
      chk("illegal_count", k, 64'(cnt_o[k]), 64'(exp_cnt[k]));
      if (sb[k].size() != 0) begin
        chk("imm_value", k, imm_o[k], sb[k][0].imm);
        chk("imm_type", k, 64'(type_o[k]), 64'(sb[k][0].typ));
        chk("illegal", k, 64'(illegal_o[k]), 64'(sb[k][0].ill));
        chk("pc_out", k, pc_o[k], sb[k][0].pc);
      end else begin
        chk("idle_outputs", k, imm_o[k] | pc_o[k] | 64'(type_o[k]) | 64'(illegal_o[k]), 64'd0);
      end
      if (reset) begin
        sb[k].delete();
        exp_cnt[k] = 16'd0;
      end else begin
        if (sb[k].size() != 0 && out_ready) void'(sb[k].pop_front());
        if (flush) sb[k].delete();
      end
    end
  end

  // Driver side: records each accepted instruction's expected result.
  initial begin
    for (int k = 0; k < N; k++) exp_cnt[k] = 16'd0;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (!reset && !flush && in_valid && in_ready[k]) begin
          exp_t e;
          e = ref_decode(instruction, XL[k], pc);
          sb[k].push_back(e);
          if (e.ill && exp_cnt[k] != 16'hFFFF) exp_cnt[k] = exp_cnt[k] + 16'd1;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic rst);
    logic [31:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    reset       = rst;
    pc          = {r0, r1[31:2], 2'b00};
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [14] = '{7'h33, 7'h3B, 7'h03, 7'h67, 7'h13, 7'h1B, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h0B, 7'h7F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 13);
    if ($urandom_range(0, 15) == 0) return r;
    return {r[31:7], ops[sel]};
  endfunction

  logic [31:0] dir_vec [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
                                32'h800002B7, 32'h00309093, 32'h3002D073,
                                32'h00000000, 32'h0000003B, 32'h0000101B,
                                32'h4050D013};

  initial begin
    exp_t m;
    // Reference model against known encodings.
    m = ref_decode(32'hFFF00093, 32, 64'd0); chk("model_i", 0, m.imm, 64'hFFFF_FFFF);
    m = ref_decode(32'hFE112E23, 32, 64'd0); chk("model_s", 0, m.imm, 64'hFFFF_FFFC);
    m = ref_decode(32'hFE000CE3, 32, 64'd0); chk("model_b", 0, m.imm, 64'hFFFF_FFF8);
    m = ref_decode(32'h800002B7, 64, 64'd0); chk("model_u", 1, m.imm, 64'hFFFF_FFFF_8000_0000);
    m = ref_decode(32'h00309093, 64, 64'd0); chk("model_sh", 1, 64'({m.typ, m.imm[7:0]}), 64'h603);
    m = ref_decode(32'h3002D073, 64, 64'd0); chk("model_z", 1, 64'({m.typ, m.imm[7:0]}), 64'h605);

    // Reset, then release.
    for (int c = 0; c < 3; c++) step(1'b1, 32'h00000013, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Directed encodings, one accept every other cycle so DEPTH=1 sees all.
    for (int d = 0; d < 10; d++) begin
      step(1'b1, dir_vec[d], 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    // Backpressure: fill with out_ready low, hold, then drain in order.
    for (int d = 0; d < 4; d++) step(1'b1, dir_vec[d], 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 5; d++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming with out_ready held high.
    for (int d = 0; d < 12; d++) step(1'b1, rand_instr(), 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with entries buffered and a concurrent (illegal) push.
    step(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000017, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset with a full buffer and a nonzero illegal count.
    for (int d = 0; d < 4; d++) step(1'b1, 32'h0000003B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 499) == 0));
    end

    // Counter saturation: stream illegal words past 0xFFFF.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 65540; c++) step(1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("sat_count", 0, 64'(cnt_o[0]), 64'h FFFF);
    chk("sat_count", 1, 64'(cnt_o[1]), 64'h FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, flow-controlled immediate decode stage for the RV32/RV64 pipeline, placed between instruction fetch and the register-read/execute stage. It classifies each accepted instruction's format and sign- or zero-extends the immediate to XLEN, including formats the single-cycle generator does not cover: JALR, OP-IMM-32, shift amounts and CSR zimm. Results pass through a DEPTH-entry buffer with valid/ready handshakes on both sides, plus flush support and a saturating illegal-instruction counter.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- DEPTH, 2: number of buffer entries, 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  clears the buffer synchronously.
- in_valid  in  1  instruction/pc are valid.
- in_ready  out  1  stage can accept an entry this cycle.
- instruction  in  32  raw instruction word.
- pc  in  XLEN  PC of the instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- imm_value  out  XLEN  extended immediate of the head entry.
- imm_type  out  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (zero-extended), 7 illegal.
- illegal  out  1  head entry is an unsupported or illegal encoding.
- pc_out  out  XLEN  PC of the head entry.
- illegal_count  out  16  number of accepted illegal instructions; saturates at 0xFFFF.

## Operation
- Decode is combinational on `instruction`. Only the decoded result, `pc` and the illegal flag are stored.
- sext() means sign-extend from the field's MSB to XLEN.
- Format table:
  - If `instruction[1:0]` ≠ 2'b11: type 7, imm 0, illegal.
  - OP (0110011), and OP-32 (0111011) when XLEN=64: type 0, imm 0.
  - LOAD (0000011), JALR (1100111), OP-IMM (0010011), and OP-IMM-32 (0011011) when XLEN=64: type 1, sext(`i[31:20]`).
  - Shift exception to the I rule above: OP-IMM with funct3 001 or 101 is type 6, imm = zext(`i[24:20]`) when XLEN=32, or zext(`i[25:20]`) when XLEN=64. OP-IMM-32 shifts always use `i[24:20]`.
  - STORE (0100011): type 2, sext({`i[31:25]`, `i[11:7]`}).
  - BRANCH (1100011): type 3, sext({`i[31]`, `i[7]`, `i[30:25]`, `i[11:8]`, 0}).
  - LUI (0110111) and AUIPC (0010111): type 4, sext({`i[31:12]`, 12'b0}).
  - JAL (1101111): type 5, sext({`i[31]`, `i[19:12]`, `i[20]`, `i[30:21]`, 0}).
  - SYSTEM (1110011): if funct3[2]=1, type 6 with imm = zext(`i[19:15]`); otherwise type 1 with imm = zext(`i[31:20]`).
  - Any other opcode, including the 64-bit-only opcodes when XLEN=32: type 7, imm 0, illegal.
- Buffer is a FIFO of DEPTH entries.
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
  - Simultaneous push and pop while full is not possible, because `in_ready` = !full.
  - Simultaneous push and pop in any other state keeps the count unchanged.
- `in_ready` = !full && !reset. It has no combinational path from `out_ready`.
- `out_valid` = count ≠ 0. When `out_valid` = 0, `imm_value`, `imm_type`, `illegal` and `pc_out` are forced to 0.
- `flush`:
  - Count becomes 0 next cycle.
  - A push in the same cycle is discarded and does not increment `illegal_count`.
  - `in_ready` is unaffected by `flush`.
- `illegal_count` increments on each push whose entry is illegal. It holds at 0xFFFF and is cleared only by reset.

## Timing
- Reset values:
  - count 0, so `out_valid` 0 and all data outputs 0.
  - `illegal_count` 0.
  - `in_ready` 0 while `reset` is high, and 1 in the first cycle after `reset` falls.
- Latency: an entry accepted at edge N appears with `out_valid` = 1 after edge N, i.e. in cycle N+1.
- Throughput:
  - DEPTH ≥ 2 sustains 1 entry/cycle with `out_ready` held at 1.
  - DEPTH = 1 sustains 1 entry every 2 cycles.
- Head outputs are stable while `out_valid && !out_ready`.
- Reset mid-stream: all buffered entries are dropped and no pop is signalled.
- Pointers wrap modulo DEPTH, including non-power-of-2 depths.

## Test plan
- XLEN=32:
  - 0xFFF00093 -> imm 0xFFFFFFFF, type 1.
  - 0xFE112E23 -> 0xFFFFFFFC, type 2.
  - 0xFE000CE3 -> 0xFFFFFFF8, type 3.
  - Each appears one cycle after acceptance.
- XLEN=64:
  - 0x800002B7 -> 0xFFFFFFFF80000000, type 4.
  - 0x00309093 -> imm 3, type 6.
  - 0x3002D073 -> imm 5, type 6.
- Illegal inputs:
  - 0x00000000 -> type 7, `illegal` = 1, `illegal_count` increments.
  - 0x0000003B with XLEN=32 -> illegal.
  - Preloading the counter to 0xFFFE and applying three illegal pushes -> `illegal_count` stays at 0xFFFF.
- Backpressure, DEPTH=2, `out_ready` = 0:
  - Two pushes -> `in_ready` = 0 and the head stays stable.
  - Raise `out_ready` -> entries exit in order, one per cycle.
  - DEPTH=1 streaming -> alternating accept cycles.
- `flush` with 2 entries buffered and a concurrent push -> `out_valid` = 0 next cycle and the pushed entry never appears.
- `reset` asserted with a full buffer -> next cycle `out_valid` = 0, `illegal_count` = 0, `in_ready` = 0; `in_ready` returns to 1 after `reset` falls.
